// File: rtl/spi_ram_pkg.sv
// Shared SPI-to-RAM definitions: entry mode tag and the default line geometry.
package spi_ram_pkg;

  typedef enum logic {
    MODE_CMD  = 1'b0,
    MODE_DATA = 1'b1
  } spi_mode_e;

  localparam int SPI_BYTE_W     = 8;
  localparam int SPI_LINE_DEPTH = 320;

endpackage

// File: rtl/spi_ram_fifo_ptr.sv
// Modulo-DEPTH pointer: wraps explicitly from DEPTH-1 to 0, so DEPTH need not be a power of two.
module spi_ram_fifo_ptr #(
  parameter int DEPTH = 320
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_inc,
  input  logic                     i_clr,
  output logic [$clog2(DEPTH)-1:0] o_ptr
);

  localparam int                 PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]   LAST  = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] r_ptr;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + PTR_W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/spi_ram_fifo.sv
// First-word-fall-through FIFO carrying {mode, payload} from the SPI side to the RAM side.
// Optional SPI_RAM_FIFO_DROP_CNT_EN adds a saturating count of writes refused while full.
module spi_ram_fifo
  import spi_ram_pkg::*;
#(
  parameter int DATA_W   = SPI_BYTE_W,
  parameter int DEPTH    = SPI_LINE_DEPTH,
  parameter int AF_LEVEL = DEPTH - 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          i_SPI_data,
  input  logic                       i_SPI_mode,
  input  logic                       i_SPI_valid,
  output logic                       o_SPI_ready,
  output logic [DATA_W-1:0]          o_RAM_data,
  output logic                       o_RAM_mode,
  output logic                       o_RAM_valid,
  input  logic                       i_RAM_ready,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_almost_full
`ifdef SPI_RAM_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]                o_drop_cnt
`endif
);

  localparam int                 LVL_W    = $clog2(DEPTH + 1);
  localparam int                 PTR_W    = $clog2(DEPTH);
  localparam int                 ENTRY_W  = DATA_W + 1;
  localparam logic [LVL_W-1:0]   FULL_LVL = LVL_W'(DEPTH);
  // A negative threshold (small DEPTH with the default) means "always almost full".
  localparam int unsigned        AF_U     = (AF_LEVEL < 0) ? 0 : AF_LEVEL;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [LVL_W-1:0]   r_level;
  logic               r_almost_full;
  logic [LVL_W-1:0]   w_level_nxt;
  logic [PTR_W-1:0]   w_wr_ptr;
  logic [PTR_W-1:0]   w_rd_ptr;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  assign w_full  = (r_level == FULL_LVL);
  assign w_empty = (r_level == '0);
  // Reset and flush swallow both handshakes of their cycle.
  assign w_push  = i_SPI_valid && !w_full  && !reset && !i_flush;
  assign w_pop   = i_RAM_ready && !w_empty && !reset && !i_flush;

  spi_ram_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_push),
    .i_clr (i_flush),
    .o_ptr (w_wr_ptr)
  );

  spi_ram_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_pop),
    .i_clr (i_flush),
    .o_ptr (w_rd_ptr)
  );

  // NOTE: the storage array has no reset; contents are only meaningful between
  // the pointers, and a resettable array would block RAM inference.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_ptr] <= {i_SPI_mode, i_SPI_data};
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_level_nxt = r_level;
    if (i_flush) begin
      w_level_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_level_nxt = r_level + LVL_W'(1);
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_level       <= '0;
      r_almost_full <= 1'b0;
    end else begin
      r_level       <= w_level_nxt;
      r_almost_full <= (32'(w_level_nxt) >= AF_U);
    end
  end

`ifdef SPI_RAM_FIFO_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_drop_cnt <= '0;
    end else if (i_SPI_valid && w_full && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign o_drop_cnt = r_drop_cnt;
`endif

  // Head read is asynchronous: the slot under the read pointer is never written
  // while it holds live data, so the head stays stable during a stall.
  assign {o_RAM_mode, o_RAM_data} = r_mem[w_rd_ptr];
  assign o_RAM_valid   = !w_empty;
  assign o_SPI_ready   = !w_full;
  assign o_level       = r_level;
  assign o_almost_full = r_almost_full;

endmodule

// File: doc/spi_ram_fifo.md
SPI_RAM_FIFO -- requirements
Module: spi_ram_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload bits per entry, excluding the mode bit.
REQ-002 SHALL have parameter DEPTH, default 320, number of entries, 2..1024, not required to be a power of two.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-16, level at or above which o_almost_full asserts.
REQ-004 SHALL have port clk, input, 1, single clock for all logic; one clock, no derived or generated clocks.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port i_SPI_data, input, DATA_W, write payload.
REQ-007 SHALL have port i_SPI_mode, input, 1, command(0)/data(1) tag stored with the payload.
REQ-008 SHALL have ports i_SPI_valid (input, 1) and o_SPI_ready (output, 1), the write handshake.
REQ-009 SHALL have ports o_RAM_data (output, DATA_W), o_RAM_mode (output, 1) and o_RAM_valid (output, 1), the head entry.
REQ-010 SHALL have port i_RAM_ready, input, 1, read handshake.
REQ-011 SHALL have port i_flush, input, 1, discard all contents.
REQ-012 SHALL have ports o_level (output, $clog2(DEPTH+1)) and o_almost_full (output, 1).

Function
REQ-013 SHALL accept a write when i_SPI_valid && o_SPI_ready at the clk rising edge; o_SPI_ready = (level != DEPTH).
REQ-014 SHALL pop the head when o_RAM_valid && i_RAM_ready at the clk rising edge; o_RAM_valid = (level != 0).
REQ-015 SHALL present the head entry first-word-fall-through: a write into an empty FIFO is visible on o_RAM_* one cycle after acceptance.
REQ-016 SHALL hold o_RAM_data/o_RAM_mode stable while o_RAM_valid && !i_RAM_ready.
REQ-017 SHALL wrap each pointer from DEPTH-1 to 0 explicitly; no reliance on binary rollover.
REQ-018 SHALL leave level unchanged on a simultaneous accepted write and pop; both pointers advance.
REQ-019 SHALL never accept a write when full, and never pop when empty; drive o_SPI_ready low on full regardless of a same-cycle pop.
REQ-020 SHALL give i_flush priority over same-cycle write and pop: pointers and level go to 0, the write is discarded.
REQ-021 SHALL register o_level and o_almost_full, asserting o_almost_full iff level >= AF_LEVEL.
REQ-022 SHALL preserve entry order and the mode bit exactly (DATA_W+1 bits per entry).

Reset
REQ-023 SHALL, while reset is high, clear pointers and level, giving o_RAM_valid=0, o_SPI_ready=1, o_level=0, o_almost_full=0 and o_drop_cnt=0.
REQ-024 SHALL, on reset mid-transfer, discard all contents and ignore handshakes in that cycle; the storage array is not cleared.

Configuration
REQ-025 SHALL, with SPI_RAM_FIFO_DROP_CNT_EN defined, add output o_drop_cnt (16 bits); it increments on each cycle with i_SPI_valid && !o_SPI_ready, saturates at 16'hFFFF and is cleared by reset or i_flush.
REQ-026 SHALL, without SPI_RAM_FIFO_DROP_CNT_EN, omit the port and counter; all other behaviour is identical.

Structure
REQ-027 SHALL take from shared package spi_ram_pkg: typedef spi_mode_e (MODE_CMD=0, MODE_DATA=1), constant SPI_BYTE_W=8, constant SPI_LINE_DEPTH=320.
REQ-028 SHALL implement each pointer with sub-module spi_ram_fifo_ptr (modulo-DEPTH wrap counter with inc and clr inputs), instantiated twice.

Verification
REQ-029 SHALL cover: after reset, write 8'hA5 with mode 0 -> next cycle o_RAM_valid=1, data 8'hA5, mode 0, o_level=1.
REQ-030 SHALL cover: DEPTH=320 with reads stalled, 320 writes -> o_SPI_ready=0, o_level=320, o_almost_full=1 from level 304; the 321st write is dropped (o_drop_cnt=1 when enabled).
REQ-031 SHALL cover: full FIFO with simultaneous valid write and pop -> pop only, level 319, o_SPI_ready=1 next cycle.
REQ-032 SHALL cover: 1000 random writes and pops with DEPTH=5 -> output sequence equals input sequence including the mode bits, with wrap exercised.
REQ-033 SHALL cover: i_flush asserted with level=37 and a same-cycle write -> level 0, o_RAM_valid=0 next cycle, the written word is never output.
REQ-034 SHALL cover: reset asserted at level 12 during an active pop -> all outputs at their reset values next cycle.
